// File: rtl/dac_write.sv
// dac_write: serial transmit driver for the DAC081S101 8-bit DAC.
// Shifts the 16-bit frame {00, pd_mode, data, 0000} out MSB-first on mosi,
// with sclk idling high so the DAC samples each bit on an sclk falling edge.
// After each frame, sync_n is held high for QUIET_TICKS cycles before the next
// frame may begin.
module dac_write #(
  parameter int SCLK_DIV    = 2,
  parameter int QUIET_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic [1:0] pd_mode,
  output logic       busy,
  output logic       done,
  output logic       sync_n,
  output logic       sclk,
  output logic       mosi
);

  localparam int HW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int QW = (QUIET_TICKS > 1) ? $clog2(QUIET_TICKS) : 1;
  localparam logic [HW-1:0] HALF_LAST  = HW'(SCLK_DIV - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} stateT;

  stateT         state;
  logic [HW-1:0] halfCnt;
  logic [4:0]    bitCnt;
  logic [QW-1:0] quietCnt;
  logic [15:0]   shiftReg;
  logic [15:0]   frameWord;
  logic          acceptStart;

  assign frameWord = {2'b00, pd_mode, data, 4'b0000};

  // A new frame may start from IDLE, or directly from the last quiet cycle so
  // that a held start gives exactly QUIET_TICKS cycles of sync_n high between frames.
  always_comb begin
    acceptStart = 1'b0;
    if (start && ((state == IDLE) || ((state == QUIET) && (quietCnt == QUIET_LAST))))
      acceptStart = 1'b1;
  end

  // Frame sequencer: sclk/mosi generation, frame end, quiet time and busy/done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sync_n   <= 1'b1;
      sclk     <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      halfCnt  <= '0;
      bitCnt   <= '0;
      quietCnt <= '0;
      shiftReg <= '0;
    end else begin
      done <= 1'b0;
      if (acceptStart) begin
        shiftReg <= frameWord;
        sync_n   <= 1'b0;
        sclk     <= 1'b1;
        mosi     <= frameWord[15];
        busy     <= 1'b1;
        halfCnt  <= '0;
        bitCnt   <= '0;
        state    <= SHIFT;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          SHIFT: begin
            if (halfCnt == HALF_LAST) begin
              halfCnt <= '0;
              if (sclk) begin
                sclk   <= 1'b0;
                bitCnt <= bitCnt + 5'd1;
              end else if (bitCnt == 5'd16) begin
                sclk     <= 1'b1;
                sync_n   <= 1'b1;
                mosi     <= 1'b0;
                done     <= 1'b1;
                quietCnt <= '0;
                state    <= QUIET;
              end else begin
                sclk     <= 1'b1;
                mosi     <= shiftReg[14];
                shiftReg <= {shiftReg[14:0], 1'b0};
              end
            end else begin
              halfCnt <= halfCnt + HW'(1);
            end
          end
          QUIET: begin
            if (quietCnt == QUIET_LAST) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              quietCnt <= quietCnt + QW'(1);
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
